// File: rtl/skew_buffer.sv
// Operand skew stage for a systolic-array edge: lane i is delayed by exactly i
// cycles, and cycles without valid input become zero bubbles on every lane.
module skew_buffer #(
    parameter int N_SIZE    = 4,
    parameter int DATAWIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 valid_in,
    input  logic [DATAWIDTH-1:0] in_A [N_SIZE],
    output logic [DATAWIDTH-1:0] out  [N_SIZE]
);

    logic [DATAWIDTH-1:0] masked [N_SIZE];

    // Invalid cycles must reach the PEs as zeros, whatever in_A carries.
    always_comb begin
        for (int i = 0; i < N_SIZE; i++) begin
            masked[i] = valid_in ? in_A[i] : '0;
        end
    end

    assign out[0] = rst_n ? masked[0] : '0;

    for (genvar i = 1; i < N_SIZE; i++) begin : g_lane
        logic [DATAWIDTH-1:0] stage_q [i];
        logic [DATAWIDTH-1:0] stage_d [i];

        always_comb begin
            stage_d[0] = masked[i];
            for (int k = 1; k < i; k++) begin
                stage_d[k] = stage_q[k-1];
            end
        end

        // Free-running shift: there is no stall, so reset is the only way to flush.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                for (int k = 0; k < i; k++) begin
                    stage_q[k] <= '0;
                end
            end else begin
                stage_q <= stage_d;
            end
        end

        assign out[i] = stage_q[i-1];
    end

endmodule

// File: tb/tb_skew_buffer.sv
// Scoreboard bench for skew_buffer: stimulus pushes hand-computed output vectors,
// a negedge monitor pops and compares them for N_SIZE = 4, 1 and 8 instances.
module tb_skew_buffer;

    typedef logic [3:0][7:0] v4_t;
    typedef logic [7:0][7:0] v8_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       valid4, valid1, valid8;
    logic [7:0] inA4 [4];
    logic [7:0] out4 [4];
    logic [7:0] inA1 [1];
    logic [7:0] out1 [1];
    logic [7:0] inA8 [8];
    logic [7:0] out8 [8];

    v4_t        q4 [$];
    logic [7:0] q1 [$];
    v8_t        q8 [$];

    int total = 0;
    int bad   = 0;
    bit watch99 = 1'b0;

    skew_buffer #(.N_SIZE(4), .DATAWIDTH(8)) dut4 (
        .clk(clk), .rst_n(rst_n), .valid_in(valid4), .in_A(inA4), .out(out4)
    );
    skew_buffer #(.N_SIZE(1), .DATAWIDTH(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .valid_in(valid1), .in_A(inA1), .out(out1)
    );
    skew_buffer #(.N_SIZE(8), .DATAWIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .valid_in(valid8), .in_A(inA8), .out(out8)
    );

    function automatic v4_t mk4(input int a0, input int a1, input int a2, input int a3);
        v4_t v;
        v[0] = 8'(a0);
        v[1] = 8'(a1);
        v[2] = 8'(a2);
        v[3] = 8'(a3);
        return v;
    endfunction

    task automatic checkLane(input string name, input int lane,
                             input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s lane %0d at %0t: got %0d expected %0d",
                     name, lane, $time, act, exp);
        end
    endtask

    // Monitor: every queued expectation is compared late in its cycle.
    always @(negedge clk) begin
        v4_t        e4;
        logic [7:0] e1;
        v8_t        e8;
        if (q4.size() > 0) begin
            e4 = q4.pop_front();
            for (int i = 0; i < 4; i++) begin
                checkLane("n4_out", i, out4[i], e4[i]);
                if (watch99) begin
                    total++;
                    if (out4[i] == 8'd99) begin
                        bad++;
                        $display("[TB] FAIL n4_no99 lane %0d at %0t: got %0d required not 99",
                                 i, $time, out4[i]);
                    end
                end
            end
        end
        if (q1.size() > 0) begin
            e1 = q1.pop_front();
            checkLane("n1_out", 0, out1[0], e1);
        end
        if (q8.size() > 0) begin
            e8 = q8.pop_front();
            for (int i = 0; i < 8; i++) begin
                checkLane("n8_out", i, out8[i], e8[i]);
            end
        end
    end

    task automatic applyStimulus(input logic rstn, input logic v, input v4_t a, input v4_t e);
        @(posedge clk);
        #1;
        rst_n  = rstn;
        valid4 = v;
        for (int i = 0; i < 4; i++) inA4[i] = a[i];
        q4.push_back(e);
    endtask

    task automatic applySweep(input logic v1, input logic [7:0] a1, input logic [7:0] e1,
                              input logic v8, input v8_t a8, input v8_t e8);
        @(posedge clk);
        #1;
        valid4  = 1'b0;
        valid1  = v1;
        inA1[0] = a1;
        valid8  = v8;
        for (int i = 0; i < 8; i++) inA8[i] = a8[i];
        q1.push_back(e1);
        q8.push_back(e8);
    endtask

    task automatic runScenario2Head();
        applyStimulus(1'b1, 1'b0, mk4(99, 99, 99, 99), mk4(0, 0, 0, 0));
        applyStimulus(1'b1, 1'b1, mk4(1, 2, 3, 4),     mk4(1, 0, 0, 0));
        applyStimulus(1'b1, 1'b1, mk4(5, 6, 7, 8),     mk4(5, 2, 0, 0));
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        v4_t a, e;
        v8_t a8, e8;
        int  d;

        rst_n  = 1'b0;
        valid4 = 1'b1;
        valid1 = 1'b0;
        valid8 = 1'b0;
        for (int i = 0; i < 4; i++) inA4[i] = 8'd7;
        inA1[0] = 8'd0;
        for (int i = 0; i < 8; i++) inA8[i] = 8'd0;

        // Reset held over two edges with valid 7s on the inputs.
        applyStimulus(1'b0, 1'b1, mk4(7, 7, 7, 7), mk4(0, 0, 0, 0));

        // Skew and masking stream; 99 marks data that must never leak.
        watch99 = 1'b1;
        runScenario2Head();
        applyStimulus(1'b1, 1'b0, mk4(99, 99, 99, 99), mk4(0, 6, 3, 0));
        applyStimulus(1'b1, 1'b1, mk4(9, 10, 11, 12),  mk4(9, 0, 7, 4));
        applyStimulus(1'b1, 1'b0, mk4(99, 99, 99, 99), mk4(0, 10, 0, 8));
        applyStimulus(1'b1, 1'b1, mk4(13, 14, 15, 16), mk4(13, 0, 11, 0));
        applyStimulus(1'b1, 1'b0, mk4(99, 99, 99, 99), mk4(0, 14, 0, 12));
        applyStimulus(1'b1, 1'b1, mk4(0, 0, 0, 0),     mk4(0, 0, 15, 0));
        applyStimulus(1'b1, 1'b1, mk4(0, 0, 0, 0),     mk4(0, 0, 0, 16));
        for (int c = 10; c <= 12; c++) begin
            applyStimulus(1'b1, 1'b1, mk4(0, 0, 0, 0), mk4(0, 0, 0, 0));
        end

        // Mid-stream reset after c2: registered lanes still show old data in the
        // reset cycle, then everything in flight is gone.
        runScenario2Head();
        applyStimulus(1'b0, 1'b1, mk4(50, 51, 52, 53), mk4(0, 6, 3, 0));
        for (int c = 0; c < 4; c++) begin
            applyStimulus(1'b1, 1'b0, mk4(99, 99, 99, 99), mk4(0, 0, 0, 0));
        end
        watch99 = 1'b0;

        // Continuous stream, in_A[i] = 10*c + i, then drained with valid low.
        for (int c = 0; c < 11; c++) begin
            for (int i = 0; i < 4; i++) begin
                a[i] = 8'(10 * c + i);
                d    = c - i;
                e[i] = (d >= 0 && d < 8) ? 8'(10 * d + i) : 8'd0;
            end
            applyStimulus(1'b1, (c < 8), a, e);
        end

        // Width extremes.
        applyStimulus(1'b1, 1'b1, mk4(255, 0, 255, 128), mk4(255, 0, 0, 0));
        applyStimulus(1'b1, 1'b0, mk4(1, 1, 1, 1),       mk4(0, 0, 0, 0));
        applyStimulus(1'b1, 1'b0, mk4(1, 1, 1, 1),       mk4(0, 0, 255, 0));
        applyStimulus(1'b1, 1'b0, mk4(1, 1, 1, 1),       mk4(0, 0, 0, 128));
        applyStimulus(1'b1, 1'b0, mk4(1, 1, 1, 1),       mk4(0, 0, 0, 0));

        // Parameter sweep: N_SIZE=1 gated passthrough, N_SIZE=8 single wavefront.
        for (int k = 0; k <= 8; k++) begin
            for (int i = 0; i < 8; i++) begin
                a8[i] = (k == 0) ? 8'(8'hA0 + i) : 8'hFF;
                e8[i] = (k == i) ? 8'(8'hA0 + i) : 8'h00;
            end
            case (k)
                0:       applySweep(1'b1, 8'h5A, 8'h5A, 1'b1, a8, e8);
                1:       applySweep(1'b0, 8'h33, 8'h00, 1'b0, a8, e8);
                2:       applySweep(1'b1, 8'hC3, 8'hC3, 1'b0, a8, e8);
                default: applySweep(1'b0, 8'hEE, 8'h00, 1'b0, a8, e8);
            endcase
        end

        @(negedge clk);
        #1;
        total++;
        if (q4.size() != 0 || q1.size() != 0 || q8.size() != 0) begin
            bad++;
            $display("[TB] FAIL scoreboard_drain: got %0d/%0d/%0d pending expected 0/0/0",
                     q4.size(), q1.size(), q8.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/skew_buffer.md
Name: skew_buffer

Overview:
- Input-skewing stage for a systolic-array operand edge (BERT accelerator matmul path).
- Accepts one N_SIZE-wide vector per cycle and delays lane i by exactly i clock cycles, producing the diagonal wavefront a systolic array needs.
- Invalid input cycles are converted to zero bubbles, so downstream PEs accumulate nothing for them.

Parameters:
- N_SIZE, 4, number of lanes (array edge length); legal range >= 1.
- DATAWIDTH, 8, bit width of each lane element.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, synchronous, active-low.
- valid_in  input  1  high when in_A carries a real vector this cycle.
- in_A  input  unpacked array [N_SIZE] of DATAWIDTH  input vector, lane 0..N_SIZE-1.
- out  output  unpacked array [N_SIZE] of DATAWIDTH  skewed output vector.

Behaviour:
- Masking: masked[i] = valid_in ? in_A[i] : 0, per lane. in_A content is irrelevant when valid_in=0.
- Lane 0 has zero delay. out[0] = masked[0] combinationally, and is forced to 0 while rst_n=0.
- Lane i (i>=1) is a shift register of depth i, clocked on every rising clk edge with no enable or stall.
  - Stage 0 loads masked[i].
  - Stage k loads stage k-1.
  - out[i] = stage i-1 (registered output).
- Timing equation: out[i] during cycle t = masked[i] from cycle t-i.
  - Total storage: N_SIZE*(N_SIZE-1)/2 registers of DATAWIDTH bits.
- Reset: on a rising edge with rst_n=0, every shift-register stage clears to 0.
  - After reset release, all outputs read 0 until valid data propagates.
  - A reset asserted mid-stream discards all in-flight data, with no partial flush.
- Back-to-back valid vectors are accepted every cycle; there is no backpressure.
- Isolated invalid cycles insert a 0 slot on each lane at its own delay.
- Draining: after the last valid vector, the bench drives valid_in=1 with zeros (or valid_in=0) for N_SIZE-1 cycles so the last lane empties.
- N_SIZE=1 degenerates to a gated passthrough with no registers.
- No arithmetic is performed: values pass bit-exact, with no sign or width changes.
- Implementation uses a generate loop over lanes; per-lane depth = lane index.

Test Plan:
Cycle numbering: cycle c = the interval between rising edges, starting at the first cycle after reset release. Outputs are sampled late in the cycle (negedge).

1. Reset:
   - Stimulus: hold rst_n=0 for 2 edges with valid_in=1 and in_A={7,7,7,7}.
   - Required: all out = 0 during reset and on the first cycle after release.
2. Skew and masking stream (N_SIZE=4, DATAWIDTH=8):
   - Stimulus per cycle:
     - c0: valid=0, in_A={99,99,99,99}
     - c1: valid=1, {1,2,3,4}
     - c2: valid=1, {5,6,7,8}
     - c3: valid=0, 99s
     - c4: valid=1, {9,10,11,12}
     - c5: valid=0, 99s
     - c6: valid=1, {13,14,15,16}
     - c7: valid=0, 99s
     - c8 to c12: valid=1, zeros
   - Required outputs {out0,out1,out2,out3}:
     - c0: {0,0,0,0}
     - c1: {1,0,0,0}
     - c2: {5,2,0,0}
     - c3: {0,6,3,0}
     - c4: {9,0,7,4}
     - c5: {0,10,0,8}
     - c6: {13,0,11,0}
     - c7: {0,14,0,12}
     - c8: {0,0,15,0}
     - c9: {0,0,0,16}
     - c10 to c12: all 0
   - Required: 99 never appears on any output.
3. Continuous stream:
   - Stimulus: valid_in=1 for 8 cycles with in_A[i] = 10*c + i.
   - Required: out[i] at cycle c equals 10*(c-i) + i for c >= i, else 0.
4. Mid-stream reset:
   - Stimulus: after c2 of scenario 2, assert rst_n=0 for one edge.
   - Required: the next cycle shows out[1..3] = 0; out[0] = 0 while rst_n=0; pre-reset data never emerges.
5. Width extremes:
   - Stimulus: one valid vector {255,0,255,128}, then valid_in=0.
   - Required:
     - out[0]=255 in that same cycle
     - out[1]=0 at +1 cycle
     - out[2]=255 at +2 cycles
     - out[3]=128 at +3 cycles
     - all other slots 0.
6. Parameter sweep:
   - Stimulus: N_SIZE=1 and N_SIZE=8 with a single valid vector.
   - Required:
     - N_SIZE=1: pure gated passthrough.
     - N_SIZE=8: lane 7 emits its value exactly 7 cycles after lane 0.
